i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial audio transmitter at the output end of the effect chain. Accepts the same `data`/`vld` sample stream the effect stages produce, holds one pending sample, and serializes it MSB-first as a standard I2S frame to the DAC, with the mono sample duplicated on left and right. Generates its own bit clock and word-select from the system clock, and flags underrun and overrun.

## Interface
- `DATA_WIDTH`, 24: sample width, two's complement; must be ≤ `SLOT_WIDTH`.
- `SLOT_WIDTH`, 32: bits per channel slot.
- `SCLK_HALF`, 4: `clk` cycles per SCLK half-period; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_i`  in  DATA_WIDTH  sample from the effect chain.
- `vld_i`  in  1  one-cycle qualifier for `data_i`.
- `sclk_o`  out  1  I2S bit clock.
- `lrck_o`  out  1  word select: 0 = left, 1 = right.
- `sdata_o`  out  1  serial data.
- `frame_o`  out  1  one-cycle pulse at each frame load.
- `urun_o`  out  1  one-cycle pulse: a frame loaded with no fresh sample.
- `orun_o`  out  1  one-cycle pulse: a pending sample was overwritten.

## Operation
- Holding register `hold` plus `hold_full` flag. `vld_i` writes `hold` and sets `hold_full`. If `hold_full` is already set, the write asserts `orun_o` and the newer sample wins.
- FSM states:
  - IDLE (after reset): `sclk_o`, `lrck_o` and `sdata_o` are held at 0. Moves to RUN on the first `vld_i`, which is latched into `hold`.
  - RUN: the clock generator runs continuously. There is no return to IDLE except by reset.
- Clock generator: `div_cnt` counts 0..SCLK_HALF-1, and `sclk_o` toggles when it wraps. Bit counter `k` counts 0..2·SLOT_WIDTH-1 and advances on each SCLK falling edge, wrapping to 0. On entry to RUN, `k` = 2·SLOT_WIDTH-1 and `sclk_o` = 0.
- On each falling edge, after `k` updates:
  - `lrck_o` = (k ≥ SLOT_WIDTH).
  - `sdata_o` = sequence bit `(k-1) mod 2·SLOT_WIDTH`. This gives the one-bit I2S delay: the left MSB appears one SCLK after `lrck_o` falls.
- Frame sequence: left slot = sample MSB-first, followed by SLOT_WIDTH-DATA_WIDTH zero bits; right slot is identical.
- Frame load happens on the falling edge where k becomes 0. The 2·SLOT_WIDTH-bit shift register is loaded and `frame_o` pulses. The load source is:
  - `hold` if `hold_full` is set, which then clears `hold_full`;
  - else `data_i` if `vld_i` is high that cycle (bypass, no underrun);
  - else the previous frame sample, which asserts `urun_o`.
- `vld_i` on the load cycle with `hold_full` set: the frame takes the old `hold` and `hold` takes `data_i`. `hold_full` stays set and `orun_o` is not asserted.

## Timing
- Reset (async, `rst_n` low): all outputs are 0 immediately, FSM returns to IDLE, `hold_full` = 0, counters clear. Assertion mid-frame truncates the frame with no completion.
- All outputs are registered. `sclk_o` edges occur every SCLK_HALF `clk` cycles.
- `vld_i` accepted in IDLE at cycle t: RUN from t+1. The first SCLK falling edge (k = 0, frame load) occurs 2·SCLK_HALF cycles later, and the left MSB follows on the next falling edge.
- Frame period = 4·SCLK_HALF·SLOT_WIDTH `clk` cycles.
- Sample to MSB-on-wire latency is at most one frame period plus 2·SCLK_HALF cycles.
- `sdata_o` and `lrck_o` change only on SCLK falling edges, so they are stable at the DAC's rising-edge sampling.

## Structure
- Package `i2s_pkg`: state enum typedef (`IDLE`, `RUN`) and helper function `frame_bits(slot) = 2*slot`.
- Sub-module `i2s_clk_gen`: divider and bit counter. Outputs `sclk`, a one-cycle `fall` strobe, and `k`, with an enable input driven by RUN.

## Test plan
Bench parameters: DATA_WIDTH=8, SLOT_WIDTH=8, SCLK_HALF=2, so one frame = 64 `clk` cycles.
- Reset: hold `rst_n` low, toggle `vld_i` -> all outputs 0 and the FSM stays IDLE.
- Single sample 0xA5 -> `frame_o` pulses once. Left-slot falling edges k=1..8 carry 1,0,1,0,0,1,0,1 with `lrck_o` 0 until k=8. The right slot repeats the pattern. `urun_o` = 0.
- No further `vld_i` -> the next frame retransmits 0xA5 and `urun_o` pulses coincident with `frame_o`.
- Samples 0x11 then 0x7E within one frame -> `orun_o` pulses on the 0x7E write and the next frame transmits 0x7E.
- DATA_WIDTH=6, sample 0x2B -> each slot is 1,0,1,0,1,1,0,0 (zero-padded).
- `rst_n` low at k=5 -> outputs 0 within the same cycle. After a new `vld_i` of 0x3C, the frame restarts cleanly from k=0.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared types and helpers for the I2S transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Transmitter control state: idle until the first sample, then free-running.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits in one stereo frame (left slot + right slot).
    function automatic int frame_bits(input int slot);
        return 2 * slot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_if
// Description : Sample stream in, I2S wire and status pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  vld_i;
    logic                  sclk_o;
    logic                  lrck_o;
    logic                  sdata_o;
    logic                  frame_o;
    logic                  urun_o;
    logic                  orun_o;

    // Sample producer side (effect chain / testbench).
    modport master (
        output data_i, vld_i,
        input  sclk_o, lrck_o, sdata_o, frame_o, urun_o, orun_o
    );

    // Transmitter side.
    modport slave (
        input  data_i, vld_i,
        output sclk_o, lrck_o, sdata_o, frame_o, urun_o, orun_o
    );
endinterface
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clk_gen
// Description : SCLK divider and frame bit counter. While disabled the clock
//               parks low with the bit counter at the last frame bit, so the
//               first falling edge after enable lands on bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_HALF  = 4,
    localparam int C_KW      = $clog2(frame_bits(SLOT_WIDTH))
) (
    input  wire             clk,
    input  wire             rst_n,
    input  wire             en,
    output logic            sclk,   // registered bit clock
    output logic            fall,   // high in the cycle whose closing edge drops sclk
    output logic [C_KW-1:0] k       // bit index that applies from that falling edge
);

    localparam int c_FB = frame_bits(SLOT_WIDTH);
    localparam int c_DW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(SCLK_HALF - 1);
    localparam logic [C_KW-1:0] c_K_LAST   = C_KW'(c_FB - 1);

    logic [c_DW-1:0] div_q, div_d;
    logic            sclk_q, sclk_d;
    logic [C_KW-1:0] k_q, k_d;
    logic            w_wrap;

    // Next-state for divider, bit clock and bit counter.
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        k_d    = k_q;
        w_wrap = en && (div_q == c_DIV_LAST);
        if (!en) begin
            div_d  = '0;
            sclk_d = 1'b0;
            k_d    = c_K_LAST;
        end else if (w_wrap) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (sclk_q) begin
                k_d = (k_q == c_K_LAST) ? '0 : k_q + C_KW'(1);
            end
        end else begin
            div_d = div_q + c_DW'(1);
        end
    end

    // Counter and clock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            k_q    <= c_K_LAST;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            k_q    <= k_d;
        end
    end

    assign sclk = sclk_q;
    assign fall = w_wrap && sclk_q;
    assign k    = k_d;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : Mono sample stream to I2S transmitter. One pending sample is
//               held, loaded into a full-frame shift image at bit 0 and sent
//               MSB-first on both channels with the standard one-bit delay.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_HALF  = 4
) (
    input  wire       clk,
    input  wire       rst_n,
    i2s_tx_if.slave   bus
);

    localparam int c_FB = frame_bits(SLOT_WIDTH);
    localparam int c_KW = $clog2(c_FB);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;           // sample of the current frame
    logic [c_FB-1:0]       frame_reg_q, frame_reg_d; // sequence bit j at c_FB-1-j
    logic                  lrck_q, lrck_d;
    logic                  sdata_q, sdata_d;
    logic                  frame_q, frame_d;
    logic                  urun_q, urun_d;
    logic                  orun_q, orun_d;

    logic                  w_sclk;
    logic                  w_fall;
    logic [c_KW-1:0]       w_k;
    logic [c_KW-1:0]       w_idx;
    logic [DATA_WIDTH-1:0] w_sample;
    logic [SLOT_WIDTH-1:0] w_slot;

    // Sample left-justified in its slot, zero padded below.
    function automatic logic [SLOT_WIDTH-1:0] to_slot(input logic [DATA_WIDTH-1:0] s);
        return SLOT_WIDTH'(s) << (SLOT_WIDTH - DATA_WIDTH);
    endfunction

    i2s_clk_gen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .SCLK_HALF  (SCLK_HALF)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .sclk  (w_sclk),
        .fall  (w_fall),
        .k     (w_k)
    );

    // Control, holding register, frame load and wire-bit selection.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        last_d      = last_q;
        frame_reg_d = frame_reg_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        frame_d     = 1'b0;
        urun_d      = 1'b0;
        orun_d      = 1'b0;
        w_sample    = last_q;
        // Bit k carries sequence bit k-1; at k=0 that is the old frame's last bit.
        w_idx       = (w_k == '0) ? '0 : c_KW'(c_FB) - w_k;
        w_slot      = '0;

        case (state_q)
            IDLE: begin
                if (bus.vld_i) begin
                    hold_d      = bus.data_i;
                    hold_full_d = 1'b1;
                    state_d     = RUN;
                end
            end
            default: begin
                if (w_fall) begin
                    lrck_d  = (w_k >= c_KW'(SLOT_WIDTH));
                    sdata_d = frame_reg_q[w_idx];
                end
                if (w_fall && (w_k == '0)) begin
                    frame_d = 1'b1;
                    if (hold_full_q) begin
                        // Pending sample goes out; a same-cycle write refills hold.
                        w_sample = hold_q;
                        if (bus.vld_i) begin
                            hold_d = bus.data_i;
                        end else begin
                            hold_full_d = 1'b0;
                        end
                    end else if (bus.vld_i) begin
                        w_sample = bus.data_i;
                    end else begin
                        urun_d = 1'b1;
                    end
                    w_slot      = to_slot(w_sample);
                    frame_reg_d = {w_slot, w_slot};
                    last_d      = w_sample;
                end else if (bus.vld_i) begin
                    hold_d      = bus.data_i;
                    hold_full_d = 1'b1;
                    orun_d      = hold_full_q;
                end
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            last_q      <= '0;
            frame_reg_q <= '0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            frame_q     <= 1'b0;
            urun_q      <= 1'b0;
            orun_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            last_q      <= last_d;
            frame_reg_q <= frame_reg_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            frame_q     <= frame_d;
            urun_q      <= urun_d;
            orun_q      <= orun_d;
        end
    end

    assign bus.sclk_o  = w_sclk;
    assign bus.lrck_o  = lrck_q;
    assign bus.sdata_o = sdata_q;
    assign bus.frame_o = frame_q;
    assign bus.urun_o  = urun_q;
    assign bus.orun_o  = orun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx
// Description : Directed bench for i2s_tx (8-bit and 6-bit sample instances,
//               8-bit slots, SCLK half-period of 2 clk cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;
    import i2s_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_tx_if #(.DATA_WIDTH(8)) b8 ();
    i2s_tx_if #(.DATA_WIDTH(6)) b6 ();

    i2s_tx #(.DATA_WIDTH(8), .SLOT_WIDTH(8), .SCLK_HALF(2)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    i2s_tx #(.DATA_WIDTH(6), .SLOT_WIDTH(8), .SCLK_HALF(2)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b6.slave)
    );

    // Observed instance selector.
    logic sel = 1'b0;
    logic m_sclk, m_lrck, m_sdata, m_frame, m_urun, m_orun;
    assign m_sclk  = sel ? b6.sclk_o  : b8.sclk_o;
    assign m_lrck  = sel ? b6.lrck_o  : b8.lrck_o;
    assign m_sdata = sel ? b6.sdata_o : b8.sdata_o;
    assign m_frame = sel ? b6.frame_o : b8.frame_o;
    assign m_urun  = sel ? b6.urun_o  : b8.urun_o;
    assign m_orun  = sel ? b6.orun_o  : b8.orun_o;

    int   n_asserts = 0;
    int   n_fail    = 0;
    logic prev_sclk = 1'b0;
    logic fell      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_asserts++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // One clk cycle; sample 1 time unit after the rising edge.
    task automatic tick();
        prev_sclk = m_sclk;
        @(posedge clk);
        #1;
        fell = prev_sclk & ~m_sclk;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sclk"},  m_sclk,  1'b0);
        check({tag, "_lrck"},  m_lrck,  1'b0);
        check({tag, "_sdata"}, m_sdata, 1'b0);
        check({tag, "_frame"}, m_frame, 1'b0);
        check({tag, "_urun"},  m_urun,  1'b0);
        check({tag, "_orun"},  m_orun,  1'b0);
    endtask

    // Advance until a frame load pulse; n = cycles taken.
    task automatic wait_load(input string tag, output int n);
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (m_frame) break;
        end
        check({tag, "_load_seen"}, m_frame, 1'b1);
    endtask

    // Called on a load cycle: checks the load flags, then the 16 falling
    // edges k=1..15,0 of the frame, ending on the next load cycle.
    task automatic capture(input string tag, input logic [7:0] sample, input int dw,
                           input logic exp_urun);
        logic [7:0]  slot;
        logic [15:0] seq;
        int          falls;
        int          ticks;
        int          extra_frames;
        slot = sample << (8 - dw);
        seq  = {slot, slot};
        check({tag, "_frame"}, m_frame, 1'b1);
        check({tag, "_urun"},  m_urun,  exp_urun);
        check({tag, "_orun"},  m_orun,  1'b0);
        check({tag, "_lrck0"}, m_lrck,  1'b0);
        falls        = 0;
        ticks        = 0;
        extra_frames = 0;
        while (falls < 16 && ticks < 200) begin
            tick();
            ticks++;
            if (fell) begin
                falls++;
                check($sformatf("%s_k%0d_sdata", tag, falls % 16), m_sdata, seq[16 - falls]);
                check($sformatf("%s_k%0d_lrck", tag, falls % 16), m_lrck,
                      (falls >= 8 && falls < 16) ? 1'b1 : 1'b0);
            end
            if (m_frame && !(fell && falls == 16)) extra_frames++;
        end
        check({tag, "_fall_count"},   falls,        16);
        check({tag, "_single_frame"}, extra_frames, 0);
        check({tag, "_next_load"},    m_frame,      1'b1);
    endtask

    initial begin
        int n;
        int falls;
        int ticks;
        b8.vld_i  = 1'b0;
        b8.data_i = '0;
        b6.vld_i  = 1'b0;
        b6.data_i = '0;

        // Reset held: inputs wiggle, outputs stay quiet and the FSM stays idle.
        for (int i = 0; i < 4; i++) begin
            b8.vld_i  = (i % 2 == 0);
            b8.data_i = 8'h5A;
            tick();
            check_quiet($sformatf("rst%0d", i));
            check($sformatf("rst%0d_state", i), u_dut8.state_q, IDLE);
        end
        b8.vld_i = 1'b0;
        rst_n    = 1'b1;
        tick();
        check_quiet("idle");

        // Single sample 0xA5: first load 2*SCLK_HALF cycles after RUN entry.
        b8.data_i = 8'hA5;
        b8.vld_i  = 1'b1;
        tick();
        b8.vld_i  = 1'b0;
        check("a5_state", u_dut8.state_q, RUN);
        wait_load("a5", n);
        check("a5_latency", n, 4);
        capture("a5", 8'hA5, 8, 1'b0);

        // No new sample: retransmit with underrun.
        capture("a5_rep", 8'hA5, 8, 1'b1);

        // Two writes within a frame: the second overruns and wins.
        for (int i = 0; i < 5; i++) tick();
        b8.data_i = 8'h11;
        b8.vld_i  = 1'b1;
        tick();
        check("ovr_first_orun", m_orun, 1'b0);
        b8.data_i = 8'h7E;
        tick();
        b8.vld_i  = 1'b0;
        check("ovr_second_orun", m_orun, 1'b1);
        tick();
        check("ovr_orun_pulse", m_orun, 1'b0);
        wait_load("ovr", n);
        capture("ovr", 8'h7E, 8, 1'b0);

        // 6-bit samples padded into 8-bit slots.
        sel       = 1'b1;
        b6.data_i = 6'h2B;
        b6.vld_i  = 1'b1;
        tick();
        b6.vld_i  = 1'b0;
        wait_load("dw6", n);
        check("dw6_latency", n, 4);
        capture("dw6", 8'h2B, 6, 1'b0);

        // Reset in mid-frame at k=5, then restart with 0x3C.
        sel = 1'b0;
        wait_load("mid", n);
        falls = 0;
        ticks = 0;
        while (falls < 5 && ticks < 100) begin
            tick();
            ticks++;
            if (fell) falls++;
        end
        check("mid_k5_reached", falls, 5);
        check("mid_k5_sdata", m_sdata, 1'b1);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_rst");
        check("mid_rst_state", u_dut8.state_q, IDLE);
        check("mid_rst_hold_full", u_dut8.hold_full_q, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_quiet("mid_idle");
        b8.data_i = 8'h3C;
        b8.vld_i  = 1'b1;
        tick();
        b8.vld_i  = 1'b0;
        wait_load("r3c", n);
        check("r3c_latency", n, 4);
        capture("r3c", 8'h3C, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
